// File: rtl/instruction_queue.sv
// Instruction queue between fetch and issue: circular FIFO of fetched instructions plus prediction metadata.
// Define IQ_BYPASS_EN to let an empty queue forward the fetch inputs straight to the issue outputs.
module instruction_queue #(
   parameter int BITS = 4,
   parameter int SIZE = 16
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        clear_in,
   input  logic        if_valid,
   input  logic [31:0] if_inst,
   input  logic [31:0] if_pc,
   input  logic        if_pred_res,
   input  logic [31:0] if_pc_alt,
   output logic        iq_full,
   output logic        iq_empty,
   input  logic        issue_accept,
   output logic        issue_valid,
   output logic [31:0] issue_inst,
   output logic [31:0] issue_pc,
   output logic [31:0] issue_pc_B_fail,
   output logic        issue_pred_res,
   output logic [6:0]  issue_opcode,
   output logic [4:0]  issue_rd
);

   localparam logic [BITS:0] FULL_COUNT = (BITS+1)'(SIZE);

   logic [31:0]     inst_mem   [SIZE];
   logic [31:0]     pc_mem     [SIZE];
   logic [31:0]     pc_alt_mem [SIZE];
   logic            pred_mem   [SIZE];
   logic [BITS-1:0] head;
   logic [BITS-1:0] tail;
   logic [BITS:0]   count;
   logic            push;
   logic            pop;

   assign iq_full  = (count == FULL_COUNT);
   assign iq_empty = (count == '0);
   assign pop      = issue_accept && !iq_empty;

`ifdef IQ_BYPASS_EN
   logic bypass;
   assign bypass = iq_empty && if_valid && !clear_in;
   // A bypassed instruction that is accepted immediately never enters storage.
   assign push   = if_valid && !iq_full && !(bypass && issue_accept);

   always_comb begin
      issue_valid     = !iq_empty;
      issue_inst      = inst_mem[head];
      issue_pc        = pc_mem[head];
      issue_pc_B_fail = pc_alt_mem[head];
      issue_pred_res  = pred_mem[head];
      if (bypass) begin
         issue_valid     = 1'b1;
         issue_inst      = if_inst;
         issue_pc        = if_pc;
         issue_pc_B_fail = if_pc_alt;
         issue_pred_res  = if_pred_res;
      end
   end
`else
   assign push            = if_valid && !iq_full;
   assign issue_valid     = !iq_empty;
   assign issue_inst      = inst_mem[head];
   assign issue_pc        = pc_mem[head];
   assign issue_pc_B_fail = pc_alt_mem[head];
   assign issue_pred_res  = pred_mem[head];
`endif

   assign issue_opcode = issue_inst[6:0];
   assign issue_rd     = issue_inst[11:7];

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         // NOTE: storage is reset on purpose: the head entry is visible on the outputs straight out of reset.
         for (int i = 0; i < SIZE; i++) begin
            inst_mem[i]   <= '0;
            pc_mem[i]     <= '0;
            pc_alt_mem[i] <= '0;
            pred_mem[i]   <= 1'b0;
         end
      end else if (rdy_in) begin
         if (clear_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (push) begin
               inst_mem[tail]   <= if_inst;
               pc_mem[tail]     <= if_pc;
               pc_alt_mem[tail] <= if_pc_alt;
               pred_mem[tail]   <= if_pred_res;
               tail             <= tail + BITS'(1);
            end
            if (pop) begin
               head <= head + BITS'(1);
            end
            case ({push, pop})
               2'b10:   count <= count + (BITS+1)'(1);
               2'b01:   count <= count - (BITS+1)'(1);
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instruction_queue.sv
// Directed self-checking bench for instruction_queue: reset, fill/drop, wrap, flush, stall, field decode.
// The IQ_BYPASS_EN section matches whichever build of the queue is compiled.
module tb_instruction_queue;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, clear_in;
   logic        if_valid, if_pred_res, issue_accept;
   logic [31:0] if_inst, if_pc, if_pc_alt;
   logic        iq_full, iq_empty, issue_valid, issue_pred_res;
   logic [31:0] issue_inst, issue_pc, issue_pc_B_fail;
   logic [6:0]  issue_opcode;
   logic [4:0]  issue_rd;

   int checks = 0;
   int errors = 0;

   instruction_queue dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .rdy_in          (rdy_in),
      .clear_in        (clear_in),
      .if_valid        (if_valid),
      .if_inst         (if_inst),
      .if_pc           (if_pc),
      .if_pred_res     (if_pred_res),
      .if_pc_alt       (if_pc_alt),
      .iq_full         (iq_full),
      .iq_empty        (iq_empty),
      .issue_accept    (issue_accept),
      .issue_valid     (issue_valid),
      .issue_inst      (issue_inst),
      .issue_pc        (issue_pc),
      .issue_pc_B_fail (issue_pc_B_fail),
      .issue_pred_res  (issue_pred_res),
      .issue_opcode    (issue_opcode),
      .issue_rd        (issue_rd)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs are changed 2 time units after an edge; outputs are sampled at the same point.
   task automatic tick();
      @(posedge clk_in);
      #2;
   endtask

   task automatic idle();
      if_valid = 1'b0; issue_accept = 1'b0; clear_in = 1'b0;
   endtask

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
      if_valid = 1'b0; if_inst = '0; if_pc = '0; if_pred_res = 1'b0; if_pc_alt = '0;
      issue_accept = 1'b0;
      tick(); tick();
      rst_in = 1'b0;

      check("rst_empty", 32'(iq_empty), 32'd1);
      check("rst_full", 32'(iq_full), 32'd0);
      check("rst_valid", 32'(issue_valid), 32'd0);
      check("rst_pc", issue_pc, 32'd0);
      check("rst_inst", issue_inst, 32'd0);
      check("rst_count", 32'(dut.count), 32'd0);

      // Three pushes without accepts
      for (int i = 0; i < 3; i++) begin
         if_valid = 1'b1; if_pc = 32'(4 * i); if_inst = 32'h1000 + 32'(i);
         tick();
      end
      idle();
      check("p3_count", 32'(dut.count), 32'd3);
      check("p3_pc", issue_pc, 32'h0);
      check("p3_valid", 32'(issue_valid), 32'd1);
      check("p3_empty", 32'(iq_empty), 32'd0);
      issue_accept = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("p3_drain_pc", issue_pc, 32'(4 * i));
         tick();
      end
      idle();
      check("p3_drained", 32'(iq_empty), 32'd1);

      // Fill to 16, then an extra push must be dropped
      for (int i = 0; i < 16; i++) begin
         if_valid = 1'b1; if_pc = 32'h100 + 32'(4 * i); if_inst = 32'h2000 + 32'(i);
         tick();
      end
      check("fill_full", 32'(iq_full), 32'd1);
      check("fill_count", 32'(dut.count), 32'd16);
      if_pc = 32'h200; if_inst = 32'h3000;
      tick();
      idle();
      check("drop_count", 32'(dut.count), 32'd16);
      check("drop_full", 32'(iq_full), 32'd1);
      check("drop_tail", 32'(dut.tail), 32'd3);
      issue_accept = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("fill_drain_pc", issue_pc, 32'h100 + 32'(4 * i));
         tick();
      end
      idle();
      check("fill_empty", 32'(iq_empty), 32'd1);
      check("fill_valid", 32'(issue_valid), 32'd0);

      // Steady push+accept for 40 cycles at count=2 (pointers wrap)
      for (int i = 0; i < 2; i++) begin
         if_valid = 1'b1; if_pc = 32'h300 + 32'(4 * i);
         tick();
      end
      for (int i = 0; i < 40; i++) begin
         if_valid = 1'b1; issue_accept = 1'b1; if_pc = 32'h308 + 32'(4 * i);
         check("steady_pc", issue_pc, 32'h300 + 32'(4 * i));
         tick();
         check("steady_count", 32'(dut.count), 32'd2);
      end
      idle();
      check("steady_head", issue_pc, 32'h3A0);

      // Flush at count=5 overrides same-cycle push and pop
      for (int i = 0; i < 3; i++) begin
         if_valid = 1'b1; if_pc = 32'h500 + 32'(4 * i);
         tick();
      end
      idle();
      check("pre_clear_count", 32'(dut.count), 32'd5);
      clear_in = 1'b1; if_valid = 1'b1; issue_accept = 1'b1; if_pc = 32'h5F0;
      tick();
      idle();
      check("clr_count", 32'(dut.count), 32'd0);
      check("clr_valid", 32'(issue_valid), 32'd0);
      check("clr_empty", 32'(iq_empty), 32'd1);
      check("clr_head", 32'(dut.head), 32'd0);
      check("clr_tail", 32'(dut.tail), 32'd0);

      // rdy_in low freezes everything, including clear
      for (int i = 0; i < 2; i++) begin
         if_valid = 1'b1; if_pc = 32'h600 + 32'(4 * i);
         tick();
      end
      rdy_in = 1'b0; if_valid = 1'b1; issue_accept = 1'b1; clear_in = 1'b1; if_pc = 32'h700;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_count", 32'(dut.count), 32'd2);
         check("stall_head", 32'(dut.head), 32'd0);
         check("stall_tail", 32'(dut.tail), 32'd2);
         check("stall_pc", issue_pc, 32'h600);
      end
      rdy_in = 1'b1; idle();
      clear_in = 1'b1;
      tick();
      idle();
      check("stall_flushed", 32'(iq_empty), 32'd1);

      // Field decode of addi x1,x0,10
      if_inst = 32'h00A00093; if_pc = 32'h40; if_pred_res = 1'b1; if_pc_alt = 32'h44;
`ifdef IQ_BYPASS_EN
      if_valid = 1'b1; issue_accept = 1'b1;
      #1;
      check("byp_valid", 32'(issue_valid), 32'd1);
      check("byp_opcode", 32'(issue_opcode), 32'h13);
      check("byp_rd", 32'(issue_rd), 32'd1);
      check("byp_alt", issue_pc_B_fail, 32'h44);
      check("byp_pred", 32'(issue_pred_res), 32'd1);
      tick();
      idle();
      check("byp_count", 32'(dut.count), 32'd0);
      if_valid = 1'b1;
`else
      if_valid = 1'b1;
      #1;
      check("nobyp_valid", 32'(issue_valid), 32'd0);
`endif
      tick();
      idle();
      check("dec_count", 32'(dut.count), 32'd1);
      check("dec_opcode", 32'(issue_opcode), 32'h13);
      check("dec_rd", 32'(issue_rd), 32'd1);
      check("dec_pc", issue_pc, 32'h40);
      check("dec_alt", issue_pc_B_fail, 32'h44);
      check("dec_pred", 32'(issue_pred_res), 32'd1);

      // Reset wins over rdy_in=0 and clears storage
      rst_in = 1'b1; rdy_in = 1'b0;
      tick();
      rst_in = 1'b0; rdy_in = 1'b1;
      check("rst2_count", 32'(dut.count), 32'd0);
      check("rst2_empty", 32'(iq_empty), 32'd1);
      check("rst2_pc", issue_pc, 32'd0);
      check("rst2_inst", issue_inst, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
